generador_dpwm: RTL and testbench

GENERADOR_DPWM -- requirements
Module: generador_dpwm

---
 rtl/generador_dpwm.sv | 91 +++++++++
 tb/tb_generador_dpwm.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/generador_dpwm.sv
// DPWM generator: 256-slot period stretched by 2^frec, frequency/duty latched only at period wrap.
// All outputs registered (one clock after the deciding edge); free-running, no backpressure.
module generador_dpwm (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] numero_frec,
  input  logic [7:0] ciclo_trabajo,
  output logic       pwm_out,
  output logic       fin_periodo,
  output logic [2:0] frec_activa
);

  logic       en_q, en_d;
  logic [6:0] presc_q, presc_d;
  logic [7:0] cuenta_q, cuenta_d;
  logic [2:0] frec_act_q, frec_act_d;
  logic [7:0] duty_act_q, duty_act_d;
  logic       pwm_q, pwm_d;
  logic       fin_q, fin_d;

  logic [7:0] limite;
  logic       tick;

  // 8-bit compare so code 7 yields 127 without wrapping the prescaler width
  assign limite = (8'd1 << frec_act_q) - 8'd1;
  assign tick   = ({1'b0, presc_q} == limite);

  always_comb begin
    en_d       = en_q;
    presc_d    = presc_q;
    cuenta_d   = cuenta_q;
    frec_act_d = frec_act_q;
    duty_act_d = duty_act_q;
    pwm_d      = pwm_q;
    fin_d      = 1'b0;

    if (!enable) begin
      en_d       = 1'b0;
      presc_d    = '0;
      cuenta_d   = '0;
      pwm_d      = 1'b0;
      frec_act_d = numero_frec;
      duty_act_d = ciclo_trabajo;
    end else if (!en_q) begin
      // start-up edge: slot 0 is presented here, counting begins next edge
      en_d     = 1'b1;
      presc_d  = '0;
      cuenta_d = '0;
      pwm_d    = (duty_act_q != 8'd0);
    end else begin
      if (tick) begin
        presc_d  = '0;
        cuenta_d = cuenta_q + 8'd1;
        if (cuenta_q == 8'hff) begin
          frec_act_d = numero_frec;
          duty_act_d = ciclo_trabajo;
          fin_d      = 1'b1;
        end
      end else begin
        presc_d = presc_q + 7'd1;
      end
      pwm_d = (cuenta_d < duty_act_d);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q       <= 1'b0;
      presc_q    <= '0;
      cuenta_q   <= '0;
      frec_act_q <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      presc_q    <= presc_d;
      cuenta_q   <= cuenta_d;
      frec_act_q <= frec_act_d;
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
      fin_q      <= fin_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign fin_periodo = fin_q;
  assign frec_activa = frec_act_q;

endmodule

// File: tb/tb_generador_dpwm.sv
// Bench for generador_dpwm: closed-form expected waveform per edge, queued and compared after each edge.
module tb_generador_dpwm;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] numero_frec;
  logic [7:0] ciclo_trabajo;
  logic       pwm_out;
  logic       fin_periodo;
  logic [2:0] frec_activa;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       pwm;
    logic       fin;
    logic [2:0] frec;
  } exp_t;

  typedef struct {
    int f;
    int d;
    int periods;
    int exp_period;
    int exp_high;
  } vec_t;

  exp_t sb[$];

  generador_dpwm dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .numero_frec(numero_frec),
    .ciclo_trabajo(ciclo_trabajo),
    .pwm_out(pwm_out),
    .fin_periodo(fin_periodo),
    .frec_activa(frec_activa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Expected outputs after edge k, where k=0 is the start-up (or wrap) edge of a period.
  function automatic exp_t model(input int k, input int f, input int d);
    exp_t e;
    int   slot;
    slot   = (k >> f) % 256;
    e.pwm  = (slot < d);
    e.fin  = (k > 0) && ((k % (256 << f)) == 0);
    e.frec = 3'(f);
    return e;
  endfunction

  task automatic cyc(input exp_t e, input string name, input int k);
    exp_t w;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    w = sb.pop_front();
    checks++;
    if (pwm_out !== w.pwm || fin_periodo !== w.fin || frec_activa !== w.frec) begin
      errors++;
      $display("FAIL %s k=%0d: got pwm=%b fin=%b frec=%0d expected pwm=%b fin=%b frec=%0d",
               name, k, pwm_out, fin_periodo, frec_activa, w.pwm, w.fin, w.frec);
    end
  endtask

  task automatic dis_cyc(input int f, input string name);
    exp_t e;
    e.pwm = 1'b0; e.fin = 1'b0; e.frec = 3'(f);
    cyc(e, name, -1);
  endtask

  task automatic run(input int f, input int d, input int k0, input int k1, input bit fin0,
                     input string name, output int hi, output int first_fin);
    exp_t e;
    hi = 0;
    first_fin = -1;
    for (int k = k0; k <= k1; k++) begin
      e = model(k, f, d);
      if (fin0 && k == 0) e.fin = 1'b1;
      cyc(e, name, k);
      if (k < (256 << f) && pwm_out === 1'b1) hi++;
      if (k > 0 && fin_periodo === 1'b1 && first_fin < 0) first_fin = k;
    end
  endtask

  task automatic setup_start(input int f, input int d);
    enable = 1'b0; numero_frec = 3'(f); ciclo_trabajo = 8'(d);
    dis_cyc(f, "stopped_load");
    dis_cyc(f, "stopped_load");
    enable = 1'b1;
  endtask

  vec_t vecs[6];

  initial begin
    int hi, ff, hi2, ff2;

    vecs[0] = '{f:0, d:64,  periods:2, exp_period:256,  exp_high:64};
    vecs[1] = '{f:3, d:128, periods:2, exp_period:2048, exp_high:1024};
    vecs[2] = '{f:0, d:0,   periods:2, exp_period:256,  exp_high:0};
    vecs[3] = '{f:0, d:255, periods:2, exp_period:256,  exp_high:255};
    vecs[4] = '{f:2, d:200, periods:1, exp_period:1024, exp_high:800};
    vecs[5] = '{f:5, d:3,   periods:1, exp_period:8192, exp_high:96};

    reset = 1'b0; enable = 1'b0; numero_frec = 3'd0; ciclo_trabajo = 8'd64;
    #3;
    chk("reset_pwm", int'(pwm_out), 0);
    chk("reset_fin", int'(fin_periodo), 0);
    chk("reset_frec", int'(frec_activa), 0);
    @(posedge clk); @(negedge clk);
    chk("reset_hold_pwm", int'(pwm_out), 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      setup_start(vecs[i].f, vecs[i].d);
      run(vecs[i].f, vecs[i].d, 0, vecs[i].periods * vecs[i].exp_period, 1'b0, "vec", hi, ff);
      chk($sformatf("vec%0d_high_time", i), hi, vecs[i].exp_high);
      chk($sformatf("vec%0d_period", i), ff, vecs[i].exp_period);
    end

    // Inputs change at slot 100: current period untouched, new values from the wrap edge.
    setup_start(0, 64);
    run(0, 64, 0, 100, 1'b0, "mid_change_a", hi, ff);
    numero_frec = 3'd1; ciclo_trabajo = 8'd200;
    run(0, 64, 101, 255, 1'b0, "mid_change_b", hi2, ff2);
    chk("mid_change_old_high", hi + hi2, 64);
    run(1, 200, 0, 512, 1'b1, "mid_change_new", hi, ff);
    chk("mid_change_new_high", hi, 400);
    chk("mid_change_new_period", ff, 512);

    // Abort at slot 150 while high, restart with inputs changed during the stop.
    setup_start(0, 200);
    run(0, 200, 0, 150, 1'b0, "abort_pre", hi, ff);
    enable = 1'b0; numero_frec = 3'd1; ciclo_trabajo = 8'd10;
    dis_cyc(1, "abort_edge");
    enable = 1'b1;
    run(1, 10, 0, 512, 1'b0, "restart", hi, ff);
    chk("restart_high", hi, 20);
    chk("restart_period", ff, 512);

    // Asynchronous reset between edges at slot 200 while pwm is high.
    setup_start(1, 255);
    run(1, 255, 0, 400, 1'b0, "pre_reset", hi, ff);
    chk("pre_reset_pwm_high", int'(pwm_out), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_pwm", int'(pwm_out), 0);
    chk("async_reset_fin", int'(fin_periodo), 0);
    chk("async_reset_frec", int'(frec_activa), 0);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    // Start-up from cleared registers: first period runs at code 0 / duty 0, then loads inputs.
    run(0, 0, 0, 255, 1'b0, "post_reset_first", hi, ff);
    chk("post_reset_first_high", hi, 0);
    run(1, 255, 0, 512, 1'b1, "post_reset_second", hi, ff);
    chk("post_reset_second_high", hi, 510);
    chk("post_reset_second_period", ff, 512);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
